// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, shared with the scaler and frame-buffer logic.
// Frame and line totals are derived at elaboration.
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [11:0] cnt_t;

  function automatic cnt_t to_cnt(input int v);
    return cnt_t'(v);
  endfunction
endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle: syncs, active-area flag, counters and frame-start strobe.
// master drives, slave (scaler, frame buffer) observes.
interface video_timing_gen_if;
  import vga_timing_pkg::*;

  logic horiz_sync;
  logic vert_sync;
  logic video_on;
  cnt_t pixel_row;
  cnt_t pixel_column;
  logic frame_start;

  modport master (
    output horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_start
  );
  modport slave (
    input horiz_sync, vert_sync, video_on, pixel_row, pixel_column, frame_start
  );
endinterface

// File: rtl/video_timing_gen_wrap_counter.sv
// Modulo counter with enable; cnt_d_o exposes the next value so callers can register
// outputs that line up with the counter. wrap_o is high on the edge that returns to 0.
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter cnt_t MODULUS = cnt_t'(VGA_H_TOTAL),
  parameter cnt_t RST_VAL = cnt_t'(VGA_H_TOTAL - 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  output cnt_t cnt_o,
  output cnt_t cnt_d_o,
  output logic wrap_o
);
  cnt_t cnt_q;
  cnt_t cnt_d;

  always_comb begin
    wrap_o = inc_i && (cnt_q == MODULUS - 12'd1);
    cnt_d  = cnt_q;
    if (reset) begin
      cnt_d = RST_VAL;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: every output is a register updated on the same pix_en edge
// as the counters, so syncs/video_on never skew against pixel_row/pixel_column.
module video_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  video_timing_gen_if.master vid
);
  localparam cnt_t H_TOTAL  = to_cnt(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam cnt_t V_TOTAL  = to_cnt(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam cnt_t H_ACT    = to_cnt(H_ACTIVE);
  localparam cnt_t V_ACT    = to_cnt(V_ACTIVE);
  localparam cnt_t HS_START = to_cnt(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = to_cnt(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = to_cnt(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = to_cnt(V_ACTIVE + V_FP + V_SYNC);

  cnt_t col_q, col_d, row_q, row_d;
  logic col_wrap, row_wrap;
  logic video_on_q, video_on_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frame_start_q;

  wrap_counter #(
    .MODULUS (H_TOTAL),
    .RST_VAL (H_TOTAL - 12'd1)
  ) u_col_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (pix_en),
    .cnt_o   (col_q),
    .cnt_d_o (col_d),
    .wrap_o  (col_wrap)
  );

  wrap_counter #(
    .MODULUS (V_TOTAL),
    .RST_VAL (V_TOTAL - 12'd1)
  ) u_row_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (col_wrap),
    .cnt_o   (row_q),
    .cnt_d_o (row_d),
    .wrap_o  (row_wrap)
  );

  // Decode from the counters' next values so the registered flags match them.
  always_comb begin
    video_on_d = (col_d < H_ACT) && (row_d < V_ACT);
    hsync_d    = !((col_d >= HS_START) && (col_d < HS_END));
    vsync_d    = !((row_d >= VS_START) && (row_d < VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      video_on_q    <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      // (0,0) is only reachable by both counters wrapping on an enabled edge.
      frame_start_q <= row_wrap;
      if (pix_en) begin
        video_on_q <= video_on_d;
        hsync_q    <= hsync_d;
        vsync_q    <= vsync_d;
      end
    end
  end

  assign vid.pixel_column = col_q;
  assign vid.pixel_row    = row_q;
  assign vid.video_on     = video_on_q;
  assign vid.horiz_sync   = hsync_q;
  assign vid.vert_sync    = vsync_q;
  assign vid.frame_start  = frame_start_q;
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-002 The block SHALL expose these parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch

REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel-rate enable; counters advance only on clk edges where pix_en=1
- horiz_sync  out  1  active-low horizontal sync
- vert_sync  out  1  active-low vertical sync
- video_on  out  1  high while the current (column,row) is in the active area
- pixel_row  out  12  current line count, 0..V_TOTAL-1
- pixel_column  out  12  current pixel count, 0..H_TOTAL-1
- frame_start  out  1  one-clk pulse when the counters become (0,0)

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (525).
REQ-005 The column counter SHALL increment by 1 on each clk edge with pix_en=1, and wrap from H_TOTAL-1 to 0.
REQ-006 The row counter SHALL increment only on the edge where the column counter wraps, and wrap from V_TOTAL-1 to 0 on that same edge.
REQ-007 When pix_en=0, all outputs and counters SHALL hold, except frame_start, which is forced to 0.
REQ-008 All outputs SHALL be registered and SHALL update on the same edge as the counters, so every output is always a consistent function of the pixel_row/pixel_column values presented in that cycle. There is zero cycles of skew between outputs.
REQ-009 video_on SHALL be 1 iff pixel_column < H_ACTIVE and pixel_row < V_ACTIVE.
REQ-010 horiz_sync SHALL be 0 iff H_ACTIVE+H_FP <= pixel_column < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-011 vert_sync SHALL be 0 iff V_ACTIVE+V_FP <= pixel_row < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-012 pixel_row and pixel_column SHALL carry the full counter values through blanking, unclipped. The downstream scaler relies on out-of-range values to flag blanking.
REQ-013 frame_start SHALL be 1 for exactly one clk, namely the cycle in which the counters first present (0,0). It SHALL be 0 in every other cycle, including held (pix_en=0) cycles at (0,0).
REQ-014 Counter comparisons SHALL be done at 12-bit width. The parameter sums are computed at elaboration.

Reset
REQ-015 While reset=1, the column counter SHALL load H_TOTAL-1 (799) and the row counter SHALL load V_TOTAL-1 (524). Outputs SHALL be pixel_column=799, pixel_row=524, video_on=0, horiz_sync=1, vert_sync=1 and frame_start=0.
REQ-016 Reset SHALL take priority over pix_en.
REQ-017 The first pix_en=1 edge after reset deasserts SHALL move the counters to (0,0) and assert frame_start.
REQ-018 Reset asserted mid-frame SHALL abandon the frame immediately, with no partial-line completion.

Structure
REQ-019 The default timing constants and the derived H_TOTAL/V_TOTAL SHALL reside in shared package vga_timing_pkg, so the scaler and the frame-buffer logic use the same values.
REQ-020 Horizontal and vertical counting SHALL use one sub-module, wrap_counter. It is parameterised by modulus and reset value, takes an increment enable, and produces a wrap output; it is instantiated twice.
REQ-021 The block SHALL contain no latches and no combinational outputs.

Verification
REQ-022 Reset for 3 clks with pix_en=1, then release -> outputs read (799,524,video_on=0,hs=1,vs=1) during reset; the next edge gives (0,0), video_on=1, frame_start=1; the following edge gives (1,0) with frame_start=0.
REQ-023 Free-run with pix_en=1 -> horiz_sync is low for exactly 96 clks starting at column 656; line period is 800 clks; video_on is high for columns 0..639 only.
REQ-024 Free-run over 2 frames -> vert_sync is low for rows 490..491 (1600 clks); frame_start pulses are exactly 420000 clks apart; row wraps 524->0 on column 799->0.
REQ-025 pix_en high 1 of every 4 clks (100 MHz/25 MHz) -> outputs hold on non-enabled clks; frame_start stays high for exactly 1 clk; frame period is 1680000 clks.
REQ-026 Reset asserted at (300,200) -> the next edge presents (799,524) with video_on=0; after release the counting restarts from (0,0).
REQ-027 Scoreboard check, every cycle: video_on == (col<640 && row<480). When driving the scaler, the image address is row*320+col only for col<320 and row<240.
